// File: rtl/pi_hit_accum_if.sv
// Stream/result bundle between the sample driver, the hit accumulator and the readout.
interface pi_hit_accum_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start;
    logic                 abort;
    logic                 op_lt_1;
    logic                 coord_valid;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] pi_est;

    modport master (
        output start, abort, op_lt_1, coord_valid, result_ready,
        input  busy, result_valid, hit_count, pi_est
    );

    modport slave (
        input  start, abort, op_lt_1, coord_valid, result_ready,
        output busy, result_valid, hit_count, pi_est
    );
endinterface

// File: rtl/pi_hit_accum.sv
// Counts unit-circle hits over 2^LOG2_SAMPLES strobes and reports 4*hits/N
// as an unsigned Q3.(CNT_WIDTH-3) value behind a valid/ready handshake.
module pi_hit_accum #(
    parameter int CNT_WIDTH    = 32,
    parameter int LOG2_SAMPLES = 20
) (
    input  logic           clk,
    input  logic           rst,
    pi_hit_accum_if.slave  bus
);
    localparam int SHIFT = CNT_WIDTH - 1 - LOG2_SAMPLES;
    localparam logic [LOG2_SAMPLES:0] LAST = {1'b0, {LOG2_SAMPLES{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state, state_nxt;
    logic [LOG2_SAMPLES:0]  sample_cnt, hit_cnt, hit_nxt;
    logic [CNT_WIDTH-1:0]   hit_count, pi_est, hit_ext;
    logic                   batch_start, counting, final_strobe;

    // A new batch opens from IDLE, or straight out of DONE on the accepting handshake.
    assign batch_start  = bus.start && ((state == IDLE) ||
                                        (state == DONE && bus.result_ready));
    assign counting     = (state == RUN) && bus.coord_valid && !bus.abort;
    assign final_strobe = counting && (sample_cnt == LAST);
    assign hit_nxt      = hit_cnt + {{LOG2_SAMPLES{1'b0}}, bus.op_lt_1};
    assign hit_ext      = CNT_WIDTH'(hit_nxt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (bus.abort) state_nxt = IDLE;
                     else if (final_strobe) state_nxt = DONE;
            DONE:    if (bus.result_ready) state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy         = (state == RUN);
        bus.result_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
            hit_cnt    <= '0;
        end else if (batch_start) begin
            sample_cnt <= '0;
            hit_cnt    <= '0;
        end else if (counting) begin
            sample_cnt <= sample_cnt + 1'b1;
            hit_cnt    <= hit_nxt;
        end
    end

    // Results are only captured on a completed batch; abort leaves the old ones in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
            pi_est    <= '0;
        end else if (final_strobe) begin
            hit_count <= hit_ext;
            pi_est    <= hit_ext << SHIFT;
        end
    end

    assign bus.hit_count = hit_count;
    assign bus.pi_est    = pi_est;
endmodule

// File: tb/tb_pi_hit_accum.sv
// Directed bench for pi_hit_accum with N=16 batches and hand-computed results.
module tb_pi_hit_accum;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pi_hit_accum_if #(.CNT_WIDTH(CW)) bus ();

    pi_hit_accum #(.CNT_WIDTH(CW), .LOG2_SAMPLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic hit);
        bus.coord_valid = 1'b1;
        bus.op_lt_1     = hit;
        step();
        bus.coord_valid = 1'b0;
        bus.op_lt_1     = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.op_lt_1 = 0;
        bus.coord_valid = 0; bus.result_ready = 0;
        #2;
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_valid", {31'b0, bus.result_valid}, 0);
        chk("rst_hits", bus.hit_count, 0);
        chk("rst_pi", bus.pi_est, 0);
        step();
        rst = 1'b0;
        step();

        // 1: all hits
        pulse_start();
        chk("t1_busy", {31'b0, bus.busy}, 1);
        for (int i = 0; i < 15; i++) strobe(1'b1);
        chk("t1_valid_early", {31'b0, bus.result_valid}, 0);
        strobe(1'b1);
        chk("t1_valid", {31'b0, bus.result_valid}, 1);
        chk("t1_hits", bus.hit_count, 16);
        chk("t1_pi", bus.pi_est, 32'h8000_0000);
        handshake();
        chk("t1_valid_drop", {31'b0, bus.result_valid}, 0);
        chk("t1_hits_hold", bus.hit_count, 16);

        // 2: 12 hits, gaps, op_lt_1 toggling while unqualified
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            strobe(i % 4 != 3);
            for (int g = 0; g < i % 3; g++) begin
                bus.op_lt_1 = ~bus.op_lt_1;
                step();
            end
        end
        chk("t2_hits", bus.hit_count, 12);
        chk("t2_pi", bus.pi_est, 32'h6000_0000);
        chk("t2_busy", {31'b0, bus.busy}, 0);
        chk("t2_valid", {31'b0, bus.result_valid}, 1);

        // 3: hold in DONE with extra strobes and start, then back-to-back batch
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 5);
            strobe(1'b1);
        end
        bus.start = 1'b0;
        chk("t3_hold_valid", {31'b0, bus.result_valid}, 1);
        chk("t3_hold_hits", bus.hit_count, 12);
        chk("t3_hold_pi", bus.pi_est, 32'h6000_0000);
        bus.result_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.start = 1'b0;
        chk("t3_b2b_busy", {31'b0, bus.busy}, 1);
        chk("t3_b2b_valid", {31'b0, bus.result_valid}, 0);
        chk("t3_b2b_cnt", {27'b0, dut.sample_cnt}, 0);
        for (int i = 0; i < 16; i++) strobe(i[0]);
        chk("t3_hits", bus.hit_count, 8);
        chk("t3_pi", bus.pi_est, 32'h4000_0000);
        handshake();

        // 4: abort mid-batch, then a 4-hit batch
        pulse_start();
        for (int i = 0; i < 10; i++) strobe(1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t4_abort_busy", {31'b0, bus.busy}, 0);
        for (int i = 0; i < 10; i++) strobe(1'b1);
        chk("t4_abort_valid", {31'b0, bus.result_valid}, 0);
        chk("t4_abort_hits_kept", bus.hit_count, 8);
        pulse_start();
        for (int i = 0; i < 16; i++) strobe(i % 4 == 0);
        chk("t4_hits", bus.hit_count, 4);
        chk("t4_pi", bus.pi_est, 32'h2000_0000);
        handshake();

        // 5: reset mid-batch and in DONE
        pulse_start();
        for (int i = 0; i < 7; i++) strobe(1'b1);
        rst = 1'b1;
        #1;
        chk("t5_run_rst_busy", {31'b0, bus.busy}, 0);
        chk("t5_run_rst_hits", bus.hit_count, 0);
        chk("t5_run_rst_pi", bus.pi_est, 0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < 16; i++) strobe(1'b1);
        chk("t5_done_valid", {31'b0, bus.result_valid}, 1);
        rst = 1'b1;
        #1;
        chk("t5_done_rst_valid", {31'b0, bus.result_valid}, 0);
        chk("t5_done_rst_hits", bus.hit_count, 0);
        chk("t5_done_rst_pi", bus.pi_est, 0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < 16; i++) strobe(i < 10);
        chk("t5_hits", bus.hit_count, 10);
        chk("t5_pi", bus.pi_est, 32'h5000_0000);
        handshake();

        // 6: abort beats the final strobe; start in RUN is ignored
        pulse_start();
        for (int i = 0; i < 15; i++) strobe(1'b1);
        bus.abort = 1'b1;
        strobe(1'b1);
        bus.abort = 1'b0;
        chk("t6_abort_last_valid", {31'b0, bus.result_valid}, 0);
        chk("t6_abort_last_busy", {31'b0, bus.busy}, 0);
        step();
        chk("t6_abort_last_hits", bus.hit_count, 10);
        pulse_start();
        for (int i = 0; i < 8; i++) strobe(1'b1);
        pulse_start();
        for (int i = 0; i < 7; i++) strobe(1'b0);
        chk("t6_restart_ignored", {31'b0, bus.result_valid}, 0);
        strobe(1'b0);
        chk("t6_valid", {31'b0, bus.result_valid}, 1);
        chk("t6_hits", bus.hit_count, 8);
        chk("t6_pi", bus.pi_est, 32'h4000_0000);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("t6_abort_done_valid", {31'b0, bus.result_valid}, 1);
        handshake();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("t6_start_wins", {31'b0, bus.busy}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
